// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, ROM word-address generation and the
// IF/ID pipeline register with stall, flush, redirect and misalignment report.
module instr_fetch_unit #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic [DATA_WIDTH-1:0] rom_rd,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [DATA_WIDTH-1:0] pc_f,
  output logic [DATA_WIDTH-1:0] if_id_instr,
  output logic [DATA_WIDTH-1:0] if_id_pc,
  output logic [DATA_WIDTH-1:0] if_id_pc4,
  output logic                  if_id_valid,
  output logic                  misalign_err
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] ipc_q, ipc_d;
  logic [DATA_WIDTH-1:0] ipc4_q, ipc4_d;
  logic                  valid_q, valid_d;
  logic                  misalign_q, misalign_d;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] win_offset;

  // Offset into the ROM window; truncation gives the modulo-depth wrap.
  always_comb begin
    win_offset = pc_q - RESET_PC;
    rom_addr   = win_offset[ADDR_WIDTH+1:2];
    pc_plus4   = pc_q + DATA_WIDTH'(4);
  end

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    ipc_d      = ipc_q;
    ipc4_d     = ipc4_q;
    valid_d    = valid_q;
    misalign_d = redirect_valid && (redirect_pc[1:0] != 2'b00);

    if (redirect_valid) begin
      pc_d = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
    end else if (!stall) begin
      pc_d = pc_plus4;
    end

    if (flush || redirect_valid) begin
      instr_d = NOP;
      ipc_d   = '0;
      ipc4_d  = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d = rom_rd;
      ipc_d   = pc_q;
      ipc4_d  = pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP;
      ipc_q      <= '0;
      ipc4_q     <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      ipc_q      <= ipc_d;
      ipc4_q     <= ipc4_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_f         = pc_q;
  assign if_id_instr  = instr_q;
  assign if_id_pc     = ipc_q;
  assign if_id_pc4    = ipc4_q;
  assign if_id_valid  = valid_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; the ROM returns 32'h1000_0000 + word address.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] rom_rd;
  logic [9:0]  rom_addr;
  logic [31:0] pc_f;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        misalign_err;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  assign rom_rd = 32'h1000_0000 + {22'd0, rom_addr};

  instr_fetch_unit #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(10),
    .RESET_PC  (32'h0040_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .rom_rd        (rom_rd),
    .rom_addr      (rom_addr),
    .pc_f          (pc_f),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .misalign_err  (misalign_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_if(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] pc4, input logic valid);
    chk({tag, ".instr"}, if_id_instr, instr);
    chk({tag, ".pc"},    if_id_pc,    pc);
    chk({tag, ".pc4"},   if_id_pc4,   pc4);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
  endtask

  task automatic chk_bubble(input string tag);
    chk_if(tag, 32'h0000_0013, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    step(); step();
    chk("rst.pc_f", pc_f, 32'h0040_0000);
    chk_bubble("rst");
    chk("rst.misalign", {31'd0, misalign_err}, 32'd0);

    // release: first cycle has rom_addr 0 and no valid entry yet
    rst_n = 1'b1;
    #1;
    chk("rel.rom_addr", {22'd0, rom_addr}, 32'd0);
    chk("rel.valid", {31'd0, if_id_valid}, 32'd0);
    step();
    chk("run1.pc_f", pc_f, 32'h0040_0004);
    chk_if("run1", 32'h1000_0000, 32'h0040_0000, 32'h0040_0004, 1'b1);
    step();
    chk("run2.pc_f", pc_f, 32'h0040_0008);
    chk_if("run2", 32'h1000_0001, 32'h0040_0004, 32'h0040_0008, 1'b1);

    // stall for 3 cycles at 0x00400008
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.pc_f", pc_f, 32'h0040_0008);
      chk_if("stall", 32'h1000_0001, 32'h0040_0004, 32'h0040_0008, 1'b1);
    end
    stall = 1'b0;
    step();
    chk("resume.pc_f", pc_f, 32'h0040_000C);
    chk_if("resume", 32'h1000_0002, 32'h0040_0008, 32'h0040_000C, 1'b1);
    step();
    chk("run4.pc_f", pc_f, 32'h0040_0010);
    chk_if("run4", 32'h1000_0003, 32'h0040_000C, 32'h0040_0010, 1'b1);

    // aligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0040;
    step();
    redirect_valid = 1'b0;
    chk("redir.pc_f", pc_f, 32'h0040_0040);
    chk_bubble("redir");
    chk("redir.misalign", {31'd0, misalign_err}, 32'd0);
    step();
    chk("redir2.pc_f", pc_f, 32'h0040_0044);
    chk_if("redir2", 32'h1000_0010, 32'h0040_0040, 32'h0040_0044, 1'b1);

    // misaligned redirect under stall
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0022; stall = 1'b1;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    chk("misal.pc_f", pc_f, 32'h0040_0020);
    chk_bubble("misal");
    chk("misal.err1", {31'd0, misalign_err}, 32'd1);
    step();
    chk("misal.err2", {31'd0, misalign_err}, 32'd0);
    chk("misal2.pc_f", pc_f, 32'h0040_0024);
    chk_if("misal2", 32'h1000_0008, 32'h0040_0020, 32'h0040_0024, 1'b1);

    // flush alone: bubble, PC keeps going
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush.pc_f", pc_f, 32'h0040_0028);
    chk_bubble("flush");
    step();
    chk("flush2.pc_f", pc_f, 32'h0040_002C);
    chk_if("flush2", 32'h1000_000A, 32'h0040_0028, 32'h0040_002C, 1'b1);

    // flush with stall: bubble, PC held
    flush = 1'b1; stall = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0;
    chk("fstall.pc_f", pc_f, 32'h0040_002C);
    chk_bubble("fstall");
    step();
    chk("fstall2.pc_f", pc_f, 32'h0040_0030);
    chk_if("fstall2", 32'h1000_000B, 32'h0040_002C, 32'h0040_0030, 1'b1);

    // window wrap above and below
    redirect_valid = 1'b1; redirect_pc = 32'h0040_1000;
    step();
    redirect_valid = 1'b0;
    chk("wrap.pc_f", pc_f, 32'h0040_1000);
    chk("wrap.rom_addr", {22'd0, rom_addr}, 32'd0);
    step();
    chk("wrap2.rom_addr", {22'd0, rom_addr}, 32'd1);
    chk_if("wrap2", 32'h1000_0000, 32'h0040_1000, 32'h0040_1004, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h003F_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("below.rom_addr", {22'd0, rom_addr}, 32'h3FF);

    // 32-bit PC wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("pcwrap.pc_f", pc_f, 32'hFFFF_FFFC);
    step();
    chk("pcwrap2.pc_f", pc_f, 32'h0000_0000);
    chk("pcwrap2.pc", if_id_pc, 32'hFFFF_FFFC);
    chk("pcwrap2.pc4", if_id_pc4, 32'h0000_0000);

    // reset overrides stall + flush + misaligned redirect
    rst_n = 1'b0; stall = 1'b1; flush = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0082;
    step();
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    chk("rst2.pc_f", pc_f, 32'h0040_0000);
    chk_bubble("rst2");
    chk("rst2.misalign", {31'd0, misalign_err}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel2.rom_addr", {22'd0, rom_addr}, 32'd0);
    step();
    chk("rel2.pc_f", pc_f, 32'h0040_0004);
    chk_if("rel2", 32'h1000_0000, 32'h0040_0000, 32'h0040_0004, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction and PC width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, word-address width of the instruction ROM.
REQ-003 SHALL have parameter RESET_PC, default 32'h0040_0000, PC after reset and base of the ROM window.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port stall  input  1  hold PC and IF/ID register.
REQ-007 SHALL have port flush  input  1  replace the next IF/ID contents with a bubble.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump taken this cycle.
REQ-009 SHALL have port redirect_pc  input  DATA_WIDTH  branch/jump target.
REQ-010 SHALL have port rom_rd  input  DATA_WIDTH  instruction word returned combinationally by the ROM.
REQ-011 SHALL have port rom_addr  output  ADDR_WIDTH  ROM word address.
REQ-012 SHALL have port pc_f  output  DATA_WIDTH  current fetch PC.
REQ-013 SHALL have port if_id_instr  output  DATA_WIDTH  registered instruction to decode.
REQ-014 SHALL have port if_id_pc  output  DATA_WIDTH  registered PC of if_id_instr.
REQ-015 SHALL have port if_id_pc4  output  DATA_WIDTH  registered if_id_pc + 4.
REQ-016 SHALL have port if_id_valid  output  1  IF/ID holds a real instruction.
REQ-017 SHALL have port misalign_err  output  1  one-cycle pulse for a misaligned redirect.

Function
REQ-018 rom_addr SHALL be combinational: bits [ADDR_WIDTH+1:2] of (pc_f - RESET_PC), wrapping modulo 2**ADDR_WIDTH when the PC is outside the window.
REQ-019 PC next-state priority SHALL be: reset, then redirect_valid (pc_f <= {redirect_pc[31:2],2'b00}), then stall (hold), else pc_f + 4 with 32-bit wrap.
REQ-020 Redirect SHALL override stall: a redirect in a stalled cycle still loads the target.
REQ-021 IF/ID next-state priority SHALL be: reset, then flush or redirect_valid (bubble), then stall (hold all fields), else capture rom_rd, pc_f, pc_f+4 with valid=1.
REQ-022 A bubble SHALL be: if_id_instr=32'h0000_0013 (NOP), if_id_pc=0, if_id_pc4=0, if_id_valid=0.
REQ-023 Latency SHALL be one cycle from pc_f to the matching if_id_instr/if_id_pc.
REQ-024 After a redirect, the first valid IF/ID entry SHALL carry the target PC, two edges after the redirect cycle; no wrong-path instruction SHALL ever show if_id_valid=1.
REQ-025 flush with stall SHALL produce a bubble; flush alone SHALL NOT alter the PC.
REQ-026 misalign_err SHALL be registered: 1 in the cycle after any redirect_valid with redirect_pc[1:0]!=0, else 0.
REQ-027 Stall SHALL be sustainable indefinitely with all outputs stable.

Reset
REQ-028 While rst_n=0 at a rising edge: pc_f=RESET_PC, IF/ID=bubble (REQ-022), misalign_err=0.
REQ-029 Reset asserted mid-operation SHALL override stall, flush and redirect in the same cycle.
REQ-030 In the first cycle after reset release, rom_addr SHALL be 0, and if_id_valid SHALL be 0 until the following edge.

Verification
REQ-031 Reset then 4 free-run cycles, ROM word n = 32'h1000_0000+n -> pc_f 0x00400000..0x00400010; if_id_instr 0x10000000..0x10000003 one cycle behind; if_id_pc4 = if_id_pc+4.
REQ-032 stall held 3 cycles at pc_f=0x00400008 -> pc_f, if_id_* and if_id_valid unchanged for 3 cycles; resume gives 0x0040000C next.
REQ-033 redirect_valid=1, redirect_pc=0x00400040 -> next edge: pc_f=0x00400040 and IF/ID bubble; following edge: if_id_pc=0x00400040, instr=ROM word 16, valid=1.
REQ-034 redirect_valid with stall=1, redirect_pc=0x00400022 -> pc_f=0x00400020, bubble, misalign_err=1 for exactly one cycle.
REQ-035 flush=1 one cycle, no redirect -> if_id_instr=0x00000013, valid=0; pc_f keeps incrementing.
REQ-036 pc_f=0x00401000 (beyond 1024 words) -> rom_addr wraps to 0; rst_n=0 during active stall+redirect -> pc_f=0x00400000 next edge.
